// File: rtl/v60_mem_pkg.sv
// Shared types and constants for the v60 bus memory responder.
// Bus widths default to 32 bits unless the build defines them beforehand.
`ifndef V60_ADDR_WIDTH
`define V60_ADDR_WIDTH 32
`endif
`ifndef V60_DATA_WIDTH
`define V60_DATA_WIDTH 32
`endif

package v60_mem_pkg;

    localparam int ADDR_WIDTH = `V60_ADDR_WIDTH;
    localparam int DATA_WIDTH = `V60_DATA_WIDTH;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Byte lanes touched by an access of the given size, before address rotation.
    function automatic logic [3:0] size_lanes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/v60_mem_array.sv
// Four byte-lane storage banks with byte-address rotation for unaligned
// accesses and a backdoor byte port that takes priority over bus writes.
module v60_mem_array
    import v60_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int BW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [BW-1:0] acc_addr,
    input  logic [1:0]    acc_size,
    input  logic          wr_en,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    input  logic          ld_en,
    input  logic [BW-1:0] ld_addr,
    input  logic [7:0]    ld_data
);

    localparam int WORDS = DEPTH / 4;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [1:0]    off;
    logic [IW-1:0] base_idx;
    logic [3:0]    size_mask;
    logic [3:0]    lane_we;
    logic [1:0]    lane_byte [4];
    logic [1:0]    rd_lane [4];
    logic [7:0]    lane_wd [4];
    logic [IW-1:0] lane_idx [4];
    logic [7:0]    lane_rd [4];

    // Lanes below the start offset belong to the next word of an unaligned access.
    always_comb begin
        off       = acc_addr[1:0];
        base_idx  = IW'(acc_addr >> 2);
        size_mask = size_lanes(acc_size);
        lane_we   = '0;
        for (int l = 0; l < 4; l++) begin
            lane_byte[l] = 2'(l) - off;
            lane_idx[l]  = (2'(l) < off) ? base_idx + IW'(1) : base_idx;
            lane_we[l]   = wr_en & size_mask[lane_byte[l]];
            lane_wd[l]   = wdata[{lane_byte[l], 3'b000} +: 8];
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rd_lane[i] = 2'(i) + acc_addr[1:0];
            rdata[8*i +: 8] = lane_rd[rd_lane[i]];
        end
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic       ld_hit;

        assign ld_hit = ld_en && (ld_addr[1:0] == 2'(l));

        always_ff @(posedge clk) begin
            if (ld_hit) begin
                mem[IW'(ld_addr >> 2)] <= ld_data;
            end else if (lane_we[l]) begin
                mem[lane_idx[l]] <= lane_wd[l];
            end
        end

        assign lane_rd[l] = mem[lane_idx[l]];
    end

endmodule

// File: rtl/v60_mem_model.sv
// v60 bus memory responder: request FSM with fixed wait states, size/range/
// alignment checking and registered response, backed by v60_mem_array.
//
// state | meaning
// IDLE  | waiting for mem_req; accepts and latches the request
// WAIT  | counting down wait states; commit happens when the counter is 0
// RESP  | mem_ready high for this one cycle; mem_req ignored
module v60_mem_model
    import v60_mem_pkg::*;
#(
    parameter int DEPTH           = 1024,
    parameter int WAIT_STATES     = 1,
    parameter bit ALLOW_UNALIGNED = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_req,
    input  logic                       mem_wr,
    input  logic [1:0]                 mem_size,
    input  logic [`V60_ADDR_WIDTH-1:0] mem_addr,
    input  logic [`V60_DATA_WIDTH-1:0] mem_wdata,
    output logic [`V60_DATA_WIDTH-1:0] mem_rdata,
    output logic                       mem_ready,
    output logic                       mem_err,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [7:0]                 ld_data
);

    localparam int BW = $clog2(DEPTH);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    state_e          state;
    logic [3:0]      wait_cnt;
    logic            lat_wr;
    logic [1:0]      lat_size;
    logic [AW-1:0]   lat_addr;
    logic [31:0]     lat_wdata;

    logic            cur_wr;
    logic [1:0]      cur_size;
    logic [AW-1:0]   cur_addr;
    logic [31:0]     cur_wdata;
    logic            fire;
    logic            acc_err;
    logic            arr_we;
    logic [AW:0]     span;
    logic [AW:0]     last_byte;
    logic [31:0]     arr_rdata;
    logic [31:0]     rd_masked;

    // With zero wait states the commit happens on the accepting edge, so the
    // live bus inputs stand in for the not-yet-latched request.
    always_comb begin
        cur_wr    = lat_wr;
        cur_size  = lat_size;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        fire      = 1'b0;
        if (state == IDLE) begin
            cur_wr    = mem_wr;
            cur_size  = mem_size;
            cur_addr  = mem_addr;
            cur_wdata = mem_wdata;
            fire      = mem_req && (WAIT_STATES == 0);
        end else if (state == WAIT) begin
            fire = (wait_cnt == 4'd0);
        end
    end

    // Range check uses one extra bit so an access near the top of the address
    // space cannot wrap back into the array.
    always_comb begin
        case (cur_size)
            SZ_HALF: span = (AW+1)'(1);
            SZ_WORD: span = (AW+1)'(3);
            default: span = '0;
        endcase
        last_byte = {1'b0, cur_addr} + span;
        acc_err   = (cur_size == SZ_ILLEGAL) || (last_byte >= DEPTH_LIM);
        if (!ALLOW_UNALIGNED) begin
            if ((cur_size == SZ_HALF) && cur_addr[0]) acc_err = 1'b1;
            if ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00)) acc_err = 1'b1;
        end
    end

    always_comb begin
        case (cur_size)
            SZ_BYTE: rd_masked = {24'h0, arr_rdata[7:0]};
            SZ_HALF: rd_masked = {16'h0, arr_rdata[15:0]};
            default: rd_masked = arr_rdata;
        endcase
    end

    assign arr_we = fire && cur_wr && !acc_err && rst_n;

    v60_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk      (clk),
        .acc_addr (cur_addr[BW-1:0]),
        .acc_size (cur_size),
        .wr_en    (arr_we),
        .wdata    (cur_wdata),
        .rdata    (arr_rdata),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            lat_wr    <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= fire;
            mem_err   <= fire && acc_err;
            if (fire) begin
                if (acc_err)     mem_rdata <= MEM_ERR_DATA;
                else if (cur_wr) mem_rdata <= '0;
                else             mem_rdata <= rd_masked;
            end
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        lat_wr    <= mem_wr;
                        lat_size  <= mem_size;
                        lat_addr  <= mem_addr;
                        lat_wdata <= mem_wdata;
                        if (WAIT_STATES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/v60_mem_model.md
Name: v60_mem_model

Overview:
Parametrised, synthesizable memory responder for the v60_cpu bus: byte-addressed storage, configurable depth and fixed wait states, with size/alignment/range checking and an error response. It replaces ad-hoc bench memories and serves as on-chip scratch RAM in FPGA builds. A byte-wide backdoor load port preloads programs without bus traffic.

Parameters:
DEPTH, 1024, storage size in bytes; must be a power of two, at least 4.
WAIT_STATES, 1, extra cycles between request acceptance and mem_ready; range 0..15.
ALLOW_UNALIGNED, 0, 1 = unaligned halfword/word accesses permitted; 0 = they are errors.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_req  in  1  request; held high by requester until mem_ready
mem_wr  in  1  1 = write, 0 = read
mem_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
mem_addr  in  `V60_ADDR_WIDTH  byte address
mem_wdata  in  `V60_DATA_WIDTH  write data, little-endian lanes
mem_rdata  out  `V60_DATA_WIDTH  read data, valid when mem_ready=1
mem_ready  out  1  one-cycle completion pulse
mem_err  out  1  error flag, valid only with mem_ready
ld_en  in  1  backdoor byte write enable
ld_addr  in  $clog2(DEPTH)  backdoor byte address
ld_data  in  8  backdoor byte

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n. Reset: mem_rdata=0, mem_ready=0, mem_err=0, FSM=IDLE, wait counter=0. Storage contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: mem_req=1 latches wr/size/addr/wdata. Next state is WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else RESP.
  - WAIT: counter decrements each cycle; at 0, next state is RESP.
  - RESP: mem_ready=1 for exactly this cycle. mem_req is ignored. Next state is IDLE.
- Latency: mem_ready rises WAIT_STATES+1 cycles after the edge sampling mem_req in IDLE.
- Back-to-back: mem_req still high in the cycle after RESP starts a new transaction. Throughput is one access per WAIT_STATES+2 cycles.
- Inputs are latched at acceptance. Changes to mem_addr/mem_wdata during WAIT have no effect.
- Error conditions, evaluated on latched values:
  - size=11;
  - any touched byte address >= DEPTH (full-width compare, no wrap);
  - with ALLOW_UNALIGNED=0: halfword with addr[0]=1, or word with addr[1:0]!=0.
- On error: no storage write; mem_rdata=32'hDEAD_BEEF; mem_err=1 with mem_ready.
- Reads, little-endian:
  - byte = {24'h0, m[a]};
  - half = {16'h0, m[a+1], m[a]};
  - word = {m[a+3], m[a+2], m[a+1], m[a]}.
- Read data is registered on the edge that raises mem_ready. It reflects all writes from earlier transactions.
- Writes: the byte lanes selected by size are committed on the edge that raises mem_ready; mem_rdata=0 on a successful write. Lane mapping is m[a+i] <= wdata[8i+7:8i].
- mem_rdata holds its last value when mem_ready=0.
- Backdoor: ld_en writes m[ld_addr] in any FSM state. If a bus write to the same byte commits in the same cycle, the backdoor value wins.
- Reset mid-transaction aborts it with no write and no mem_ready. A pending commit on that edge is discarded.

Decomposition:
- v60_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL;
  - MEM_ERR_DATA = 32'hDEAD_BEEF;
  - the state enum {IDLE, WAIT, RESP}.
- Sub-module v60_mem_array: 4 byte-lane storage with per-lane write enables, byte-address rotation and backdoor port. v60_mem_model holds the FSM, error checks and output registers.

Test Plan:
- WAIT_STATES=1. Backdoor-load 0x00..0x03 = B8 34 12 00, then word read at 0x0 -> mem_ready 2 cycles after acceptance, mem_rdata=0x001234B8, mem_err=0.
- Halfword write 0xBEEF at 0x10, then byte reads at 0x10 and 0x11 -> 0x000000EF and 0x000000BE; bytes 0x12/0x13 unchanged.
- ALLOW_UNALIGNED=0: word read at 0x2 -> mem_err=1, mem_rdata=0xDEADBEEF. ALLOW_UNALIGNED=1: same access -> data {m5,m4,m3,m2}, mem_err=0.
- DEPTH=1024: word write at 0x3FE (unaligned allowed) and byte read at 0x400 -> both mem_err=1, no storage change. mem_size=11 -> mem_err=1.
- WAIT_STATES=0, mem_req held high for 3 transactions -> mem_ready pulses every 2nd cycle, 3 pulses, never two consecutive.
- Assert rst_n=0 in WAIT of a word write to 0x20 -> no mem_ready, m[0x20..0x23] unchanged, all outputs 0. A backdoor write colliding with a bus write to the same byte -> backdoor value stored.
